ff_bank_arbiter: RTL and testbench

FF_BANK_ARBITER -- requirements
Module: ff_bank_arbiter

---
 rtl/ff_bank_arbiter.sv | 128 ++++++++++++
 tb/tb_ff_bank_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_bank_arbiter.sv
// ff_bank_arbiter: four requesters share one WIDTH-bit flip-flop register.
// A round-robin arbiter picks one requester, writes its data into the
// register, and acknowledges with a one-cycle ack pulse.
// Optional feature macro: TOGGLE_OP_EN adds the op port. op[i]=1 makes
// requester i's write an XOR (toggle) instead of a plain load.
//
// Handshake: a requester raises req[i] with wdata valid and holds both
// until it sees ack[i]. gnt[i] rises one edge after req[i] is sampled in
// IDLE. Dropping req[i] while the FSM is in GRANT aborts the write. ack[i]
// is high for exactly one cycle (COMMIT), and gnt[i] stays high with it.
module ff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
`ifdef TOGGLE_OP_EN
  input  logic [3:0]         op,
`endif
  output logic [3:0]         gnt,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       win, win_n;
  logic [3:0]       gnt_n, ack_n;
  logic [WIDTH-1:0] q_n;
  logic [1:0]       pick, idx;
  logic             found;
  logic [WIDTH-1:0] win_data;

  // Round-robin search: start at ptr and wrap 3->0; first active req wins.
  always_comb begin
    pick  = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign win_data = wdata[win*WIDTH +: WIDTH];

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    gnt_n   = gnt;
    ack_n   = ack;
    q_n     = q;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          win_n   = pick;
          gnt_n   = 4'b0001 << pick;
        end
      end
      GRANT: begin
        if (req[win]) begin
`ifdef TOGGLE_OP_EN
          if (op[win]) q_n = q ^ win_data;
          else         q_n = win_data;
`else
          q_n = win_data;
`endif
          state_n = COMMIT;
          ack_n   = 4'b0001 << win;
        end else begin
          // Winner withdrew: abort without writing and without moving ptr.
          state_n = IDLE;
          gnt_n   = 4'b0000;
        end
      end
      COMMIT: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        ack_n   = 4'b0000;
        ptr_n   = win + 2'd1;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        ack_n   = 4'b0000;
      end
    endcase
  end

  // State, pointer, grant/ack and the shared register; async active-low clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      ptr   <= 2'd0;
      win   <= 2'd0;
      gnt   <= 4'b0000;
      ack   <= 4'b0000;
      q     <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      win   <= win_n;
      gnt   <= gnt_n;
      ack   <= ack_n;
      q     <= q_n;
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Directed bench for ff_bank_arbiter (WIDTH=8). Toggle-op scenario is
// compiled only when TOGGLE_OP_EN is defined.
module tb_ff_bank_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             res = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic [4*WIDTH-1:0] wdata = '0;
`ifdef TOGGLE_OP_EN
  logic [3:0]       op = 4'b0000;
`endif
  logic [3:0]       gnt, ack;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic [1:0]       state_dbg;

  int checks   = 0;
  int failures = 0;

  ff_bank_arbiter #(.WIDTH(WIDTH), .NREQ(4)) dut (
    .clk       (clk),
    .res       (res),
    .req       (req),
    .wdata     (wdata),
`ifdef TOGGLE_OP_EN
    .op        (op),
`endif
    .gnt       (gnt),
    .ack       (ack),
    .q         (q),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Every-cycle invariants, sampled on the falling edge.
  always @(negedge clk) begin
    checks++;
    if (!$onehot0(gnt)) begin
      failures++;
      $display("FAIL inv_gnt_onehot gnt=%b", gnt);
    end
    checks++;
    if (!$onehot0(ack)) begin
      failures++;
      $display("FAIL inv_ack_onehot ack=%b", ack);
    end
    checks++;
    if ((ack & ~gnt) !== 4'b0000) begin
      failures++;
      $display("FAIL inv_ack_implies_gnt ack=%b gnt=%b", ack, gnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic [3:0] eg,
                            input logic [3:0] ea, input logic [7:0] eq,
                            input logic eb);
    checks++;
    if (gnt !== eg || ack !== ea || q !== eq || busy !== eb) begin
      failures++;
      $display("FAIL %s got gnt=%b ack=%b q=%h busy=%b want gnt=%b ack=%b q=%h busy=%b",
               name, gnt, ack, q, busy, eg, ea, eq, eb);
    end
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    wdata = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    res = 1'b0;
    req = 4'b0000;
    #3;
    expect_out("reset_held", 4'b0000, 4'b0000, 8'h00, 1'b0);
    tick();
    res = 1'b1;
    expect_out("reset_released", 4'b0000, 4'b0000, 8'h00, 1'b0);
  endtask

  task automatic test_single();
    set_data(8'hA5, 8'h00, 8'h00, 8'h00);
    req = 4'b0001;
    tick();
    expect_out("single_grant", 4'b0001, 4'b0000, 8'h00, 1'b1);
    tick();
    expect_out("single_commit", 4'b0001, 4'b0001, 8'hA5, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("single_idle", 4'b0000, 4'b0000, 8'hA5, 1'b0);
  endtask

  task automatic test_contend();
    logic [7:0] dat [4];
    int order [5];
    dat   = '{8'h11, 8'h22, 8'h33, 8'h44};
    order = '{0, 1, 2, 3, 0};
    test_reset();
    set_data(dat[0], dat[1], dat[2], dat[3]);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      logic [3:0] oh;
      oh = 4'b0001 << order[t];
      tick();
      expect_out($sformatf("contend_grant_%0d", t), oh, 4'b0000,
                 (t == 0) ? 8'h00 : dat[order[t-1]], 1'b1);
      // Non-winner data churn during GRANT must not affect the write.
      wdata = wdata ^ (~({{24{1'b0}}, 8'hFF} << (order[t] * 8)));
      tick();
      expect_out($sformatf("contend_commit_%0d", t), oh, oh, dat[order[t]], 1'b1);
      set_data(dat[0], dat[1], dat[2], dat[3]);
      tick();
      expect_out($sformatf("contend_idle_%0d", t), 4'b0000, 4'b0000, dat[order[t]], 1'b0);
    end
    req = 4'b0000;
    checks++;
    if (q !== 8'h11) begin
      failures++;
      $display("FAIL contend_final_q got=%h want=11", q);
    end
  endtask

  task automatic test_abort();
    test_reset();
    // Requester 3 completes, leaving ptr at 0 again.
    set_data(8'h00, 8'h00, 8'h99, 8'h77);
    req = 4'b1000;
    tick();
    tick();
    req = 4'b0000;
    tick();
    expect_out("abort_setup", 4'b0000, 4'b0000, 8'h77, 1'b0);
    req = 4'b0100;
    tick();
    expect_out("abort_grant", 4'b0100, 4'b0000, 8'h77, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("abort_idle", 4'b0000, 4'b0000, 8'h77, 1'b0);
    checks++;
    if (state_dbg !== 2'd0) begin
      failures++;
      $display("FAIL abort_state got=%0d want=0", state_dbg);
    end
    // ptr must still be 0: requester 0 beats 3 when all request.
    set_data(8'h5A, 8'h00, 8'h99, 8'h77);
    req = 4'b1111;
    tick();
    expect_out("abort_next_from_ptr0", 4'b0001, 4'b0000, 8'h77, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("abort_next_dropped", 4'b0000, 4'b0000, 8'h77, 1'b0);
  endtask

`ifdef TOGGLE_OP_EN
  task automatic test_toggle();
    test_reset();
    set_data(8'hF0, 8'hFF, 8'h00, 8'h00);
    op  = 4'b0000;
    req = 4'b0001;
    tick(); tick();
    req = 4'b0000;
    tick();
    expect_out("toggle_load_f0", 4'b0000, 4'b0000, 8'hF0, 1'b0);
    op  = 4'b0010;
    req = 4'b0010;
    tick(); tick();
    expect_out("toggle_first", 4'b0010, 4'b0010, 8'h0F, 1'b1);
    req = 4'b0000;
    tick();
    req = 4'b0010;
    tick(); tick();
    expect_out("toggle_second", 4'b0010, 4'b0010, 8'hF0, 1'b1);
    req = 4'b0000;
    op  = 4'b0000;
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    test_reset();
    set_data(8'h3C, 8'h00, 8'h00, 8'h00);
    req = 4'b0001;
    tick();
    tick();
    expect_out("midrst_commit", 4'b0001, 4'b0001, 8'h3C, 1'b1);
    #2;
    res = 1'b0;
    #1;
    expect_out("midrst_async", 4'b0000, 4'b0000, 8'h00, 1'b0);
    req = 4'b0000;
    tick();
    res = 1'b1;
    tick();
    expect_out("midrst_after1", 4'b0000, 4'b0000, 8'h00, 1'b0);
    tick();
    expect_out("midrst_after2", 4'b0000, 4'b0000, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contend();
    test_abort();
`ifdef TOGGLE_OP_EN
    test_toggle();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
